tick_ctl: RTL and testbench

- Programmable prescaler controller. It converts the free-running system clock into a single-cycle tick strobe every D clocks, in periodic or one-shot mode.
- A divisor/mode configuration is loaded through a valid/ready handshake. Runs are sequenced by start/stop pulses.
- Sits between software-visible control logic and timed consumers (LED blinkers, UART baud, debounce). It replaces fixed power-of-two clock division with exact integer division and a clock-enable output.

---
 rtl/tick_ctl.sv | 134 +++++++++++++
 tb/tb_tick_ctl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tick_ctl.sv
// ---------------------------------------------------------------------------
// tick_ctl -- programmable prescaler controller
//
// Turns the free-running clock into a one-clock tick strobe every De clocks,
// where De = max(D,1). The tick runs periodically or fires once (one-shot).
// The divisor and mode are loaded through a valid/ready handshake that is
// only open while idle. Runs are sequenced with start/stop pulses.
//
// Ports:
//   clk_i       system clock, all logic on the rising edge
//   rst_i       synchronous reset, active-high
//   cfg_stb_i   configuration valid
//   cfg_rdy_o   configuration ready (high only in IDLE)
//   cfg_div_i   divisor D (0 behaves as 1)
//   cfg_mode_i  0 = periodic, 1 = one-shot
//   start_i     start / restart request (level sampled each edge)
//   stop_i      stop request
//   tick_o      registered one-clock tick strobe
//   busy_o      high while running
//   cnt_o       current down-count value
// ---------------------------------------------------------------------------
module tick_ctl #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_stb_i,
  output logic             cfg_rdy_o,
  input  logic [WIDTH-1:0] cfg_div_i,
  input  logic             cfg_mode_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             tick_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] cnt_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] div_q,   div_d;
  logic             mode_q,  mode_d;
  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic             tick_q,  tick_d;

  logic             cfg_accept;
  logic [WIDTH-1:0] reload;

  // Reload is De-1; D=0 and D=1 both reload with zero, so a tick is due
  // on every edge.
  function automatic logic [WIDTH-1:0] reload_of(input logic [WIDTH-1:0] d);
    return (d == '0) ? '0 : d - WIDTH'(1);
  endfunction

  assign cfg_accept = cfg_stb_i && (state_q == ST_IDLE);

  // div_d already carries a divisor accepted on this same edge, so a start
  // issued together with a config strobe uses the new divisor. In RUN the
  // handshake is closed and div_d equals div_q.
  assign reload = reload_of(div_d);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;

    if (cfg_accept) begin
      div_d  = cfg_div_i;
      mode_d = cfg_mode_i;
    end

    unique case (state_q)
      ST_IDLE: begin
        // stop_i has no effect while idle
        if (start_i) begin
          state_d = ST_RUN;
          cnt_d   = reload;
        end
      end

      ST_RUN: begin
        if (stop_i) begin
          // Stop wins over a tick due on this edge and over a restart.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (start_i) begin
          cnt_d = reload;
        end else if (cnt_q == '0) begin
          tick_d = 1'b1;
          if (mode_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = reload;
          end
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_o    = tick_q;
  assign busy_o    = (state_q == ST_RUN);
  assign cfg_rdy_o = (state_q == ST_IDLE);
  assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_tick_ctl.sv
// ---------------------------------------------------------------------------
// tb_tick_ctl -- scoreboard bench for tick_ctl
//
// Each stimulus cycle drives the inputs on the falling edge and pushes the
// hand-computed outputs expected after the next rising edge into a queue.
// An independent monitor pops one entry per rising edge (sampled 1 time
// unit later) and compares tick_o, busy_o, cfg_rdy_o and cnt_o.
// ---------------------------------------------------------------------------
module tb_tick_ctl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             cfg_stb_i = 1'b0;
  logic             cfg_rdy_o;
  logic [WIDTH-1:0] cfg_div_i = '0;
  logic             cfg_mode_i = 1'b0;
  logic             start_i = 1'b0;
  logic             stop_i = 1'b0;
  logic             tick_o;
  logic             busy_o;
  logic [WIDTH-1:0] cnt_o;

  typedef struct {
    string            tag;
    logic             tick;
    logic             busy;
    logic [WIDTH-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  tick_ctl #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .cfg_stb_i  (cfg_stb_i),
    .cfg_rdy_o  (cfg_rdy_o),
    .cfg_div_i  (cfg_div_i),
    .cfg_mode_i (cfg_mode_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .tick_o     (tick_o),
    .busy_o     (busy_o),
    .cnt_o      (cnt_o)
  );

  always #5 clk = ~clk;

  // Monitor: one expected entry per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_tests++;
        if (tick_o !== e.tick || busy_o !== e.busy || cfg_rdy_o !== !e.busy ||
            cnt_o !== e.cnt) begin
          n_fail++;
          $display("[TB] FAIL %s: got tick=%b busy=%b rdy=%b cnt=%0d, expected tick=%b busy=%b rdy=%b cnt=%0d",
                   e.tag, tick_o, busy_o, cfg_rdy_o, cnt_o,
                   e.tick, e.busy, !e.busy, e.cnt);
        end else begin
          $display("[TB] ok   %s: tick=%b busy=%b rdy=%b cnt=%0d",
                   e.tag, tick_o, busy_o, cfg_rdy_o, cnt_o);
        end
      end
    end
  end

  // One clock of stimulus plus its expected response after the next edge.
  task automatic cyc(input string tag, input logic rs, input logic st,
                     input logic sp, input logic cs, input int dv,
                     input logic md, input logic et, input logic eb,
                     input int ec);
    exp_t e;
    @(negedge clk);
    rst_i      = rs;
    start_i    = st;
    stop_i     = sp;
    cfg_stb_i  = cs;
    cfg_div_i  = WIDTH'(dv);
    cfg_mode_i = md;
    e.tag  = tag;
    e.tick = et;
    e.busy = eb;
    e.cnt  = WIDTH'(ec);
    exp_q.push_back(e);
  endtask

  //                          tag rs st sp cs dv md   tick busy cnt
  task automatic idle(input string tag, input logic et, input logic eb, input int ec);
    cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, et, eb, ec);
  endtask

  initial begin
    // --- reset state
    cyc("reset",      1, 0, 0, 0, 0, 0,  0, 0, 0);

    // --- D=4 periodic: ticks at E0+4, +8, +12; count 3,2,1,0,3,...
    cyc("cfg_d4",     0, 0, 0, 1, 4, 0,  0, 0, 0);
    cyc("d4_start",   0, 1, 0, 0, 0, 0,  0, 1, 3);
    for (int k = 1; k <= 12; k++)
      idle($sformatf("d4_e0+%0d", k), (k % 4) == 0, 1'b1, 3 - (k % 4));
    cyc("d4_stop",    0, 0, 1, 0, 0, 0,  0, 0, 0);

    // --- D=5 one-shot: single tick at E0+5 together with busy falling
    cyc("cfg_d5_os",  0, 0, 0, 1, 5, 1,  0, 0, 0);
    cyc("d5_start",   0, 1, 0, 0, 0, 0,  0, 1, 4);
    idle("d5_e0+1", 0, 1, 3);
    idle("d5_e0+2", 0, 1, 2);
    idle("d5_e0+3", 0, 1, 1);
    idle("d5_e0+4", 0, 1, 0);
    idle("d5_e0+5_tick", 1, 0, 0);
    for (int k = 1; k <= 20; k++)
      idle($sformatf("d5_quiet%0d", k), 0, 0, 0);

    // --- D=0 and D=1 periodic: tick every cycle from E0+1, count stays 0
    cyc("cfg_d0",     0, 0, 0, 1, 0, 0,  0, 0, 0);
    cyc("d0_start",   0, 1, 0, 0, 0, 0,  0, 1, 0);
    for (int k = 1; k <= 5; k++)
      idle($sformatf("d0_e0+%0d", k), 1, 1, 0);
    cyc("d0_stop",    0, 0, 1, 0, 0, 0,  0, 0, 0);
    cyc("cfg_d1",     0, 0, 0, 1, 1, 0,  0, 0, 0);
    cyc("d1_start",   0, 1, 0, 0, 0, 0,  0, 1, 0);
    for (int k = 1; k <= 5; k++)
      idle($sformatf("d1_e0+%0d", k), 1, 1, 0);
    cyc("d1_stop",    0, 0, 1, 0, 0, 0,  0, 0, 0);

    // --- D=3: cfg in RUN ignored; stop on the cnt==0 edge beats the tick
    cyc("cfg_d3",     0, 0, 0, 1, 3, 0,  0, 0, 0);
    cyc("d3_start",   0, 1, 0, 0, 0, 0,  0, 1, 2);
    cyc("d3_cfg9_run",0, 0, 0, 1, 9, 1,  0, 1, 1);
    idle("d3_e0+2", 0, 1, 0);
    cyc("d3_stop_at0",0, 0, 1, 0, 0, 0,  0, 0, 0);
    cyc("idle_stop",  0, 0, 1, 0, 0, 0,  0, 0, 0);
    // Divisor must still be 3 (a 9 would reload 8) and mode still periodic.
    cyc("d3_restart", 0, 1, 0, 0, 0, 0,  0, 1, 2);
    idle("d3r_e0+1", 0, 1, 1);
    idle("d3r_e0+2", 0, 1, 0);
    idle("d3r_e0+3", 1, 1, 2);
    idle("d3r_e0+4", 0, 1, 1);
    cyc("d3r_stop",   0, 0, 1, 0, 0, 0,  0, 0, 0);

    // --- cfg D=2 together with start; restart at cnt==0 suppresses the tick
    cyc("cfg2_start", 0, 1, 0, 1, 2, 0,  0, 1, 1);
    idle("d2_e0+1", 0, 1, 0);
    idle("d2_e0+2", 1, 1, 1);
    idle("d2_e0+3", 0, 1, 0);
    cyc("d2_restart0",0, 1, 0, 0, 0, 0,  0, 1, 1);
    idle("d2_r+1", 0, 1, 0);
    idle("d2_r+2", 1, 1, 1);
    cyc("d2_stop",    0, 0, 1, 0, 0, 0,  0, 0, 0);

    // --- reset mid-run (D=6, cnt=2), then start without cfg gives De=1
    cyc("cfg_d6",     0, 0, 0, 1, 6, 0,  0, 0, 0);
    cyc("d6_start",   0, 1, 0, 0, 0, 0,  0, 1, 5);
    idle("d6_e0+1", 0, 1, 4);
    idle("d6_e0+2", 0, 1, 3);
    idle("d6_e0+3", 0, 1, 2);
    cyc("d6_rst",     1, 0, 0, 0, 0, 0,  0, 0, 0);
    cyc("post_rst_st",0, 1, 0, 0, 0, 0,  0, 1, 0);
    for (int k = 1; k <= 4; k++)
      idle($sformatf("post_rst_e0+%0d", k), 1, 1, 0);
    cyc("final_stop", 0, 0, 1, 0, 0, 0,  0, 0, 0);

    // Let the monitor drain the queue, with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
